dmem_axi_bridge: RTL and testbench

Data-side memory interface for the pipelined MIPS core. Sits directly downstream of the datapath's memory stage. Converts the single outstanding load/store presented in M (address, byte strobes, size, store data) into one AXI3 single-beat read or write transaction. Produces `stallreq_from_mem` to freeze the pipeline until the transaction completes, and returns the raw 32-bit read word as `readdataM`.

---
 rtl/dmem_axi_bridge_pkg.sv | 30 +++
 rtl/dmem_axi_bridge.sv | 154 +++++++++++++++
 tb/tb_dmem_axi_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_axi_bridge_pkg.sv
// Shared definitions for the data-side AXI bridge: FSM states, access size codes
// and the constant AXI fields the wrapper ties off.
package dmem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } bridgeState_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] AXI_ID         = 4'd1;
  localparam logic [3:0] AXI_LEN        = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic isStore(input logic [3:0] wen);
    return wen != 4'b0000;
  endfunction

  function automatic logic [2:0] axiSize(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/dmem_axi_bridge.sv
// Turns the single M-stage load/store into one AXI3 single-beat transaction and
// holds the pipeline via stallreq_from_mem until it completes.
//
// state   | meaning
// IDLE    | waiting for a qualified M-stage access
// RD_ADDR | read address offered, waiting for arready
// RD_DATA | waiting for the single read beat
// WR_REQ  | AW and W offered together, each retired independently
// WR_RESP | waiting for the write response
// DONE    | result available, stall released; parked here while pipe_hold
module dmem_axi_bridge
  import dmem_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  input  logic        pipe_hold,
  output logic [31:0] readdataM,
  output logic        stallreq_from_mem,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  output logic        wlast,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  bridgeState_t state;
  logic [31:0]  addrReg;
  logic [31:0]  wdataReg;
  logic [1:0]   sizeReg;
  logic [3:0]   strbReg;
  logic         awDone;
  logic         wDone;
  logic         awHs;
  logic         wHs;
  logic         unusedRlast;

  // len is always 0, so the single beat is by construction the last one
  assign unusedRlast = rlast;

  assign awHs = awvalid & awready;
  assign wHs  = wvalid & wready;

  assign araddr = addrReg;
  assign awaddr = addrReg;
  assign arsize = axiSize(sizeReg);
  assign awsize = axiSize(sizeReg);
  assign wdata  = wdataReg;
  assign wstrb  = strbReg;

  assign stallreq_from_mem = ((state == IDLE) & mem_en) |
                             ((state != IDLE) & (state != DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addrReg   <= '0;
      wdataReg  <= '0;
      sizeReg   <= SIZE_BYTE;
      strbReg   <= '0;
      awDone    <= 1'b0;
      wDone     <= 1'b0;
      readdataM <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            addrReg  <= mem_addr;
            wdataReg <= mem_wdata;
            sizeReg  <= mem_size;
            strbReg  <= mem_wen;
            awDone   <= 1'b0;
            wDone    <= 1'b0;
            if (isStore(mem_wen)) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              wlast   <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            readdataM <= rdata;
            rready    <= 1'b0;
            state     <= DONE;
          end
        end
        WR_REQ: begin
          if (awHs) begin
            awvalid <= 1'b0;
            awDone  <= 1'b1;
          end
          if (wHs) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            wDone  <= 1'b1;
          end
          // Either channel may finish first; both may finish in the same cycle
          if ((awDone | awHs) & (wDone | wHs)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // While held, the same instruction is still in M; leaving would re-issue it
          if (!pipe_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Self-checking bench for dmem_axi_bridge: reactive AXI slave with programmable
// wait states, expectations derived from per-transaction cycle arithmetic.
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        pipe_hold;
  logic [31:0] readdataM;
  logic        stallreq_from_mem;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rlast, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wlast, wready;
  logic        bvalid, bready;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;

  // Per-transaction observations filled in by run_txn
  int stallCycles, doneCycles, badReaddata, unstable, wlastBad, timedOut;
  int arvCycles, arHsN, rrdyCycles, rHsN, awvCycles, awHsN, wvCycles, wHsN, brdyCycles, bHsN;
  int rHsCycle, firstAwvCycle;
  logic [31:0] hsAraddr, hsAwaddr, hsWdata;
  logic [2:0]  hsArsize, hsAwsize;
  logic [3:0]  hsWstrb;

  dmem_axi_bridge dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .pipe_hold(pipe_hold),
    .readdataM(readdataM), .stallreq_from_mem(stallreq_from_mem),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_slave();
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  // Drives one access and plays the slave; the caller does all the checking.
  task automatic run_txn(input logic [31:0] addr, input logic [1:0] size, input logic [3:0] wen,
                         input logic [31:0] wd, input logic [31:0] slaveData,
                         input int arDly, input int rDly, input int awDly, input int wDly,
                         input int bDly, input int holdCycles);
    int arW, rW, awW, wW, bW, n;
    logic pArv, pAwv, pWv, finished;
    logic [31:0] pAra, pAwa, pWd;
    logic [2:0]  pArs, pAws;
    logic [3:0]  pWs;
    stallCycles = 0; doneCycles = 0; badReaddata = 0; unstable = 0; wlastBad = 0; timedOut = 0;
    arvCycles = 0; arHsN = 0; rrdyCycles = 0; rHsN = 0; awvCycles = 0; awHsN = 0;
    wvCycles = 0; wHsN = 0; brdyCycles = 0; bHsN = 0; rHsCycle = -1; firstAwvCycle = -1;
    arW = 0; rW = 0; awW = 0; wW = 0; bW = 0; n = 0;
    pArv = 0; pAwv = 0; pWv = 0; pAra = '0; pAwa = '0; pWd = '0; pArs = '0; pAws = '0; pWs = '0;
    finished = 0;
    @(negedge clk);
    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wd; mem_size = size;
    pipe_hold = 1'b0;
    while (!finished) begin
      arready = arvalid && (arW >= arDly); if (arvalid && !arready) arW++;
      awready = awvalid && (awW >= awDly); if (awvalid && !awready) awW++;
      wready  = wvalid && (wW >= wDly);    if (wvalid && !wready) wW++;
      rvalid  = rready && (rW >= rDly);    if (rready && !rvalid) rW++;
      bvalid  = bready && (bW >= bDly);    if (bready && !bvalid) bW++;
      rdata   = rvalid ? slaveData : $urandom;
      rlast   = rvalid;
      #1;
      if (stallreq_from_mem) stallCycles++;
      else begin
        doneCycles++;
        if (wen == 4'b0000 && readdataM !== slaveData) badReaddata++;
        pipe_hold = (doneCycles <= holdCycles);
        if (!pipe_hold) finished = 1;
      end
      if (arvalid) arvCycles++;
      if (arvalid && arready) begin arHsN++; hsAraddr = araddr; hsArsize = arsize; end
      if (pArv && arvalid && (araddr !== pAra || arsize !== pArs)) unstable++;
      if (awvalid) arvCycles = arvCycles + 0;
      if (awvalid) awvCycles++;
      if (awvalid && firstAwvCycle < 0) firstAwvCycle = cycleCount;
      if (awvalid && awready) begin awHsN++; hsAwaddr = awaddr; hsAwsize = awsize; end
      if (pAwv && awvalid && (awaddr !== pAwa || awsize !== pAws)) unstable++;
      if (wvalid) wvCycles++;
      if (wvalid && wlast !== 1'b1) wlastBad++;
      if (wvalid && wready) begin wHsN++; hsWdata = wdata; hsWstrb = wstrb; end
      if (pWv && wvalid && (wdata !== pWd || wstrb !== pWs)) unstable++;
      if (rready) rrdyCycles++;
      if (rready && rvalid) begin rHsN++; rHsCycle = cycleCount; end
      if (bready) brdyCycles++;
      if (bready && bvalid) bHsN++;
      pArv = arvalid; pAra = araddr; pArs = arsize;
      pAwv = awvalid; pAwa = awaddr; pAws = awsize;
      pWv = wvalid; pWd = wdata; pWs = wstrb;
      @(posedge clk);
      n++;
      if (n > 300) begin timedOut = 1; finished = 1; end
      if (!finished) @(negedge clk);
    end
    clear_slave();
  endtask

  task automatic go_idle();
    @(negedge clk);
    mem_en = 1'b0; mem_wen = '0; pipe_hold = 1'b0;
  endtask

  task automatic test_reset();
    mem_en = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0; mem_size = '0; pipe_hold = 1'b0;
    clear_slave();
    rst = 1'b1;
    #23;
    assertCount++;
    if ({readdataM, stallreq_from_mem, araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
         wdata, wstrb, wvalid, wlast, bready} !== '0) begin
      failCount++; $display("FAIL reset_outputs: some output nonzero during reset (arvalid=%b awvalid=%b stall=%b)",
                            arvalid, awvalid, stallreq_from_mem);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    assertCount++;
    if ({stallreq_from_mem, arvalid, awvalid, wvalid, rready, bready} !== 6'b0) begin
      failCount++; $display("FAIL idle_outputs: got %b required 000000",
                            {stallreq_from_mem, arvalid, awvalid, wvalid, rready, bready});
    end
    mem_en = 1'b1; #1;
    assertCount++;
    if (stallreq_from_mem !== 1'b1) begin
      failCount++; $display("FAIL idle_stall_comb: got %b required 1", stallreq_from_mem);
    end
    mem_en = 1'b0;
  endtask

  task automatic test_load_word();
    run_txn(32'h1fc0_0100, 2'd2, 4'b0000, 32'h0, 32'hdeadbeef, 0, 0, 0, 0, 0, 0);
    assertCount++; if (timedOut !== 0) begin failCount++; $display("FAIL load_timeout: got %0d required 0", timedOut); end
    assertCount++; if (stallCycles !== 3) begin failCount++; $display("FAIL load_stall: got %0d required 3", stallCycles); end
    assertCount++; if (badReaddata !== 0 || doneCycles !== 1) begin failCount++; $display("FAIL load_data: readdataM=%h bad=%0d done=%0d required deadbeef/0/1", readdataM, badReaddata, doneCycles); end
    assertCount++; if (hsAraddr !== 32'h1fc0_0100 || hsArsize !== 3'd2) begin failCount++; $display("FAIL load_ar: got %h/%0d required 1fc00100/2", hsAraddr, hsArsize); end
    assertCount++; if (arHsN !== 1 || rHsN !== 1 || awvCycles !== 0) begin failCount++; $display("FAIL load_count: ar=%0d r=%0d aw=%0d required 1/1/0", arHsN, rHsN, awvCycles); end
    go_idle();
  endtask

  task automatic test_store_byte();
    run_txn(32'h0000_0003, 2'd0, 4'b1000, 32'h5a00_0000, 32'h0, 0, 0, 2, 0, 1, 0);
    assertCount++; if (awvCycles !== 3 || wvCycles !== 1) begin failCount++; $display("FAIL store_valids: aw=%0d w=%0d required 3/1", awvCycles, wvCycles); end
    assertCount++; if (stallCycles !== 6 || doneCycles !== 1) begin failCount++; $display("FAIL store_stall: got %0d/%0d required 6/1", stallCycles, doneCycles); end
    assertCount++; if (hsAwaddr !== 32'h3 || hsAwsize !== 3'd0) begin failCount++; $display("FAIL store_aw: got %h/%0d required 3/0", hsAwaddr, hsAwsize); end
    assertCount++; if (hsWdata !== 32'h5a00_0000 || hsWstrb !== 4'b1000 || wlastBad !== 0) begin failCount++; $display("FAIL store_w: got %h/%b wlastBad=%0d required 5a000000/1000/0", hsWdata, hsWstrb, wlastBad); end
    assertCount++; if (bHsN !== 1 || brdyCycles !== 2 || arvCycles !== 0) begin failCount++; $display("FAIL store_b: b=%0d bready=%0d ar=%0d required 1/2/0", bHsN, brdyCycles, arvCycles); end
    go_idle();
  endtask

  task automatic test_same_cycle_aw_w();
    run_txn(32'h0000_1000, 2'd2, 4'b1111, 32'h1234_5678, 32'h0, 0, 0, 0, 0, 4, 0);
    assertCount++; if (awvCycles !== 1 || wvCycles !== 1 || awHsN !== 1 || wHsN !== 1) begin failCount++; $display("FAIL same_cycle_valids: aw=%0d w=%0d required 1/1", awvCycles, wvCycles); end
    assertCount++; if (brdyCycles !== 5) begin failCount++; $display("FAIL same_cycle_resp: got %0d required 5", brdyCycles); end
    assertCount++; if (stallCycles !== 7 || doneCycles !== 1) begin failCount++; $display("FAIL same_cycle_stall: got %0d/%0d required 7/1", stallCycles, doneCycles); end
    go_idle();
  endtask

  task automatic test_pipe_hold();
    run_txn(32'h0000_2004, 2'd2, 4'b0000, 32'h0, 32'hcafe_f00d, 0, 1, 0, 0, 0, 3);
    assertCount++; if (doneCycles !== 4 || stallCycles !== 4) begin failCount++; $display("FAIL hold_done: done=%0d stall=%0d required 4/4", doneCycles, stallCycles); end
    assertCount++; if (arvCycles !== 1 || arHsN !== 1) begin failCount++; $display("FAIL hold_no_reissue: arvalid cycles=%0d required 1", arvCycles); end
    assertCount++; if (badReaddata !== 0) begin failCount++; $display("FAIL hold_readdata: bad=%0d required 0", badReaddata); end
    go_idle();
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_4000; mem_size = 2'd2;
    n = 0;
    while (!rready && n < 20) begin
      arready = arvalid;
      @(negedge clk);
      n++;
    end
    arready = 1'b0;
    @(negedge clk);
    #2; rst = 1'b1; mem_en = 1'b0; #1;
    assertCount++;
    if (n >= 20 || {readdataM, stallreq_from_mem, araddr, arsize, arvalid, rready, awaddr, awsize,
                    awvalid, wdata, wstrb, wvalid, wlast, bready} !== '0) begin
      failCount++; $display("FAIL async_reset_outputs: rready=%b readdataM=%h araddr=%h required all 0", rready, readdataM, araddr);
    end
    @(negedge clk); rst = 1'b0;
    run_txn(32'h0000_4008, 2'd1, 4'b0000, 32'h0, 32'h0bad_c0de, 0, 0, 0, 0, 0, 0);
    assertCount++; if (stallCycles !== 3 || arvCycles !== 1 || badReaddata !== 0 || rHsN !== 1) begin failCount++; $display("FAIL async_reset_fresh: stall=%0d ar=%0d bad=%0d required 3/1/0", stallCycles, arvCycles, badReaddata); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int loadRhs, loadDone, loadAr;
    run_txn(32'h0000_5000, 2'd2, 4'b0000, 32'h0, 32'h1357_9bdf, 0, 0, 0, 0, 0, 0);
    loadRhs = rHsCycle; loadDone = doneCycles; loadAr = arHsN;
    run_txn(32'h0000_5004, 2'd2, 4'b1111, 32'h2468_ace0, 32'h0, 0, 0, 0, 0, 0, 0);
    assertCount++; if (loadDone !== 1 || firstAwvCycle - loadRhs !== 3) begin failCount++; $display("FAIL b2b_gap: done=%0d gap=%0d required 1/3", loadDone, firstAwvCycle - loadRhs); end
    assertCount++; if (loadAr !== 1 || awHsN !== 1 || wHsN !== 1 || arvCycles !== 0 || bHsN !== 1) begin failCount++; $display("FAIL b2b_dup: ar=%0d aw=%0d w=%0d ar2=%0d b=%0d required 1/1/1/0/1", loadAr, awHsN, wHsN, arvCycles, bHsN); end
    go_idle();
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, sd;
    logic [1:0]  size;
    logic [3:0]  wen;
    int arD, rD, awD, wD, bD, hold, expStall, mx;
    for (int i = 0; i < 24; i++) begin
      addr = $urandom; wd = $urandom; sd = $urandom;
      size = 2'($urandom_range(0, 2));
      wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      arD = $urandom_range(0, 3); rD = $urandom_range(0, 3);
      awD = $urandom_range(0, 3); wD = $urandom_range(0, 3); bD = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      run_txn(addr, size, wen, wd, sd, arD, rD, awD, wD, bD, hold);
      assertCount++; if (timedOut !== 0 || doneCycles !== hold + 1 || unstable !== 0) begin failCount++; $display("FAIL rand_done[%0d]: timeout=%0d done=%0d unstable=%0d required 0/%0d/0", i, timedOut, doneCycles, unstable, hold + 1); end
      if (wen == 4'b0000) begin
        expStall = arD + rD + 3;
        assertCount++; if (stallCycles !== expStall) begin failCount++; $display("FAIL rand_load_stall[%0d]: got %0d required %0d", i, stallCycles, expStall); end
        assertCount++; if (hsAraddr !== addr || hsArsize !== {1'b0, size} || badReaddata !== 0) begin failCount++; $display("FAIL rand_load_data[%0d]: ar=%h/%0d bad=%0d required %h/%0d/0", i, hsAraddr, hsArsize, badReaddata, addr, size); end
        assertCount++; if (arvCycles !== arD + 1 || rrdyCycles !== rD + 1 || awvCycles !== 0) begin failCount++; $display("FAIL rand_load_valids[%0d]: ar=%0d r=%0d aw=%0d required %0d/%0d/0", i, arvCycles, rrdyCycles, awvCycles, arD + 1, rD + 1); end
      end else begin
        mx = (awD > wD) ? awD : wD;
        expStall = mx + bD + 3;
        assertCount++; if (stallCycles !== expStall) begin failCount++; $display("FAIL rand_store_stall[%0d]: got %0d required %0d", i, stallCycles, expStall); end
        assertCount++; if (hsAwaddr !== addr || hsAwsize !== {1'b0, size} || hsWdata !== wd || hsWstrb !== wen || wlastBad !== 0) begin failCount++; $display("FAIL rand_store_data[%0d]: aw=%h/%0d w=%h/%b required %h/%0d/%h/%b", i, hsAwaddr, hsAwsize, hsWdata, hsWstrb, addr, size, wd, wen); end
        assertCount++; if (awvCycles !== awD + 1 || wvCycles !== wD + 1 || brdyCycles !== bD + 1 || arvCycles !== 0) begin failCount++; $display("FAIL rand_store_valids[%0d]: aw=%0d w=%0d b=%0d ar=%0d required %0d/%0d/%0d/0", i, awvCycles, wvCycles, brdyCycles, arvCycles, awD + 1, wD + 1, bD + 1); end
      end
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_same_cycle_aw_w();
    test_pipe_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
